// File: rtl/xif_mem_responder.sv
// XIF memory-channel responder: one coprocessor request at a time onto OBI.
// Define XIF_MEM_SPEC_EN to hold speculative requests until commit/kill.
module xif_mem_responder #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_valid_i,
  output logic                    mem_ready_o,
  input  logic [X_ID_WIDTH-1:0]   mem_id_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic                    mem_we_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic                    mem_spec_i,
  output logic                    mem_resp_exc_o,
  output logic [5:0]              mem_resp_exccode_o,
  input  logic                    commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]   commit_id_i,
  input  logic                    commit_kill_i,
  output logic                    mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0]   mem_result_id_o,
  output logic [DATA_WIDTH-1:0]   mem_result_rdata_o,
  output logic                    mem_result_err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i
);

  localparam int unsigned BW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COMMIT,
    REQ,
    RESP,
    RESULT
  } state_e;

  state_e                state_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic                  we_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  req_q;
  logic                  rvld_q;

  logic hs;
  logic misal;
  logic go;
  logic drop;

  assign mem_ready_o = rst_ni & (state_q == IDLE);
  assign hs          = mem_valid_i & mem_ready_o;
  assign misal       = |mem_addr_i[1:0];

  assign mem_resp_exc_o     = hs & misal;
  assign mem_resp_exccode_o = !mem_resp_exc_o ? 6'd0 :
                              mem_we_i ? 6'd6 : 6'd4;

`ifdef XIF_MEM_SPEC_EN
  logic [X_ID_WIDTH-1:0] last_id_q;
  logic                  last_kill_q;
  logic                  last_vld_q;
  logic                  hit_now;
  logic                  hit_old;
  logic                  cmt_hit;

  // A commit in the accept cycle wins over the tracked one.
  always_comb begin
    hit_now = commit_valid_i && (commit_id_i == mem_id_i);
    hit_old = last_vld_q && (last_id_q == mem_id_i);
    cmt_hit = commit_valid_i && (commit_id_i == id_q);
    go      = !mem_spec_i;
    drop    = 1'b0;
    if (mem_spec_i) begin
      if (hit_now) begin
        go   = !commit_kill_i;
        drop = commit_kill_i;
      end else if (hit_old) begin
        go   = !last_kill_q;
        drop = last_kill_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_id_q   <= '0;
      last_kill_q <= 1'b0;
      last_vld_q  <= 1'b0;
    end else if (commit_valid_i) begin
      last_id_q   <= commit_id_i;
      last_kill_q <= commit_kill_i;
      last_vld_q  <= 1'b1;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{mem_spec_i, commit_valid_i,
                           commit_id_i, commit_kill_i};
  assign go   = 1'b1;
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hs && !misal) begin
            id_q    <= mem_id_i;
            addr_q  <= mem_addr_i[ADDR_WIDTH-1:2];
            we_q    <= mem_we_i;
            be_q    <= mem_be_i;
            wdata_q <= mem_wdata_i;
            if (go) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end else if (!drop) begin
              state_q <= WAIT_COMMIT;
            end
          end
        end
`ifdef XIF_MEM_SPEC_EN
        WAIT_COMMIT: begin
          if (cmt_hit) begin
            state_q <= commit_kill_i ? IDLE : REQ;
            req_q   <= !commit_kill_i;
          end
        end
`endif
        REQ: begin
          if (data_gnt_i) begin
            state_q <= RESP;
            req_q   <= 1'b0;
          end
        end
        RESP: begin
          if (data_rvalid_i) begin
            rdata_q <= we_q ? '0 : data_rdata_i;
            err_q   <= data_err_i;
            rvld_q  <= 1'b1;
            state_q <= RESULT;
          end
        end
        RESULT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_req_o         = req_q;
  assign data_addr_o        = {addr_q, 2'b00};
  assign data_we_o          = we_q;
  assign data_be_o          = be_q;
  assign data_wdata_o       = wdata_q;
  assign mem_result_valid_o = rvld_q;
  assign mem_result_id_o    = id_q;
  assign mem_result_rdata_o = rdata_q;
  assign mem_result_err_o   = err_q;

endmodule
